mem_access_unit: RTL and testbench

- MEM-stage responder for the memory-control bundle produced in ID: mem_read_flag, mem_write_flag, mem_sign_ext_flag, mem_sel and mem_write_data.
- Converts one load or store into a request/ready transaction on the data-RAM bus.
- Handles byte-lane steering, store-data replication, load extraction and sign/zero extension.
- Stalls the pipeline until the bus completes or times out.

---
 rtl/mem_access_unit.sv | 141 ++++++++++++++
 tb/tb_mem_access_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Purpose: MEM-stage load/store responder driving a request/ready data-RAM bus with lane steering and load extension.
// Latency: request cycle plus at least one BUSY cycle (minimum 2-cycle stall), then one DONE cycle with stall released.
// Backpressure: ram_en is held until ram_ready or the BUSY timeout; the pipeline stalls for the whole transaction.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read_flag,
  input  logic                  mem_write_flag,
  input  logic                  mem_sign_ext_flag,
  input  logic [3:0]            mem_sel,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_write_data,
  output logic                  ram_en,
  output logic [3:0]            ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_write_data,
  input  logic                  ram_ready,
  input  logic [31:0]           ram_read_data,
  output logic                  stall_request,
  output logic [31:0]           load_data,
  output logic                  addr_error,
  output logic                  bus_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] timeout_cnt;

  // Access attributes latched at request time so load extraction does not
  // depend on the upstream pipeline holding its inputs.
  logic        is_load_q;
  logic        is_byte_q;
  logic        sign_ext_q;
  logic [1:0]  lane_q;

  logic        sel_byte;
  logic        sel_word;
  logic        req;
  logic        misaligned;
  logic [7:0]  rd_byte;
  logic [31:0] load_ext;

  assign sel_byte   = (mem_sel == 4'b0001);
  assign sel_word   = (mem_sel == 4'b1111);
  assign req        = (mem_read_flag | mem_write_flag) & (sel_byte | sel_word);
  assign misaligned = sel_word & (mem_addr[1:0] != 2'b00);

  // Stall covers the accepting cycle and every BUSY cycle; DONE lets the pipe advance.
  assign stall_request = ((state == IDLE) & req & ~misaligned) | (state == BUSY);

  // Select the addressed byte lane of the returned word.
  always_comb begin
    rd_byte = ram_read_data[7:0];
    case (lane_q)
      2'd0:    rd_byte = ram_read_data[7:0];
      2'd1:    rd_byte = ram_read_data[15:8];
      2'd2:    rd_byte = ram_read_data[23:16];
      default: rd_byte = ram_read_data[31:24];
    endcase
  end

  // Byte loads extend per the latched sign flag; word loads pass through.
  assign load_ext = is_byte_q ? {{24{sign_ext_q & rd_byte[7]}}, rd_byte} : ram_read_data;

  // Transaction FSM with registered bus outputs and one-cycle error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      timeout_cnt    <= 16'd0;
      ram_en         <= 1'b0;
      ram_write_en   <= 4'b0000;
      ram_addr       <= '0;
      ram_write_data <= 32'd0;
      load_data      <= 32'd0;
      addr_error     <= 1'b0;
      bus_error      <= 1'b0;
      is_load_q      <= 1'b0;
      is_byte_q      <= 1'b0;
      sign_ext_q     <= 1'b0;
      lane_q         <= 2'd0;
    end else begin
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !misaligned) begin
            ram_en         <= 1'b1;
            // A store wins when both flags are set.
            ram_write_en   <= mem_write_flag ? (sel_word ? 4'b1111 : (4'b0001 << mem_addr[1:0]))
                                             : 4'b0000;
            ram_addr       <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
            ram_write_data <= sel_word ? mem_write_data : {4{mem_write_data[7:0]}};
            is_load_q      <= ~mem_write_flag;
            is_byte_q      <= sel_byte;
            sign_ext_q     <= mem_sign_ext_flag;
            lane_q         <= mem_addr[1:0];
            timeout_cnt    <= 16'd0;
            state          <= BUSY;
          end else if (req && misaligned) begin
            addr_error <= 1'b1;
          end
        end
        BUSY: begin
          timeout_cnt <= timeout_cnt + 16'd1;
          if (ram_ready) begin
            // Ready on the final allowed cycle still counts as success.
            ram_en       <= 1'b0;
            ram_write_en <= 4'b0000;
            if (is_load_q) begin
              load_data <= load_ext;
            end
            state <= DONE;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            ram_en       <= 1'b0;
            ram_write_en <= 4'b0000;
            load_data    <= 32'd0;
            bus_error    <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Purpose: self-checking bench for mem_access_unit using directed and randomized accesses against a behavioural model.
// Latency: each access is driven just after a rising edge and observed on the following falling edge.
// Backpressure: ram_ready is withheld for a chosen number of BUSY cycles, including past the timeout.
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int T  = 4;

  logic          clk;
  logic          rst_n;
  logic          mem_read_flag;
  logic          mem_write_flag;
  logic          mem_sign_ext_flag;
  logic [3:0]    mem_sel;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_write_data;
  logic          ram_en;
  logic [3:0]    ram_write_en;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_write_data;
  logic          ram_ready;
  logic [31:0]   ram_read_data;
  logic          stall_request;
  logic [31:0]   load_data;
  logic          addr_error;
  logic          bus_error;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_load = 32'd0;

  mem_access_unit #(
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_read_flag    (mem_read_flag),
    .mem_write_flag   (mem_write_flag),
    .mem_sign_ext_flag(mem_sign_ext_flag),
    .mem_sel          (mem_sel),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .ram_en           (ram_en),
    .ram_write_en     (ram_write_en),
    .ram_addr         (ram_addr),
    .ram_write_data   (ram_write_data),
    .ram_ready        (ram_ready),
    .ram_read_data    (ram_read_data),
    .stall_request    (stall_request),
    .load_data        (load_data),
    .addr_error       (addr_error),
    .bus_error        (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic clear_inputs();
    mem_read_flag     = 1'b0;
    mem_write_flag    = 1'b0;
    mem_sign_ext_flag = 1'b0;
    mem_sel           = 4'b0000;
    mem_addr          = '0;
    mem_write_data    = 32'd0;
  endtask

  // One access from the model's point of view. Entered and left just after a rising edge with the DUT idle.
  // delay = index of the BUSY cycle in which ram_ready is raised (>= T means never).
  task automatic do_access(input bit rd, input bit wr, input bit sx, input logic [3:0] sel,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int delay, input string tag);
    bit          word, byte_acc, req, mis, is_load, ok, rdy;
    logic [31:0] exp_addr, exp_wdata, b;
    logic [3:0]  exp_we;
    word      = (sel == 4'hF);
    byte_acc  = (sel == 4'h1);
    req       = (rd || wr) && (word || byte_acc);
    mis       = word && (addr % 4 != 0);
    is_load   = rd && !wr;
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_we    = wr ? (word ? 4'hF : 4'(1 << (addr % 4))) : 4'h0;
    exp_wdata = word ? wdata : (wdata & 32'hFF) * 32'h0101_0101;

    mem_read_flag     = rd;
    mem_write_flag    = wr;
    mem_sign_ext_flag = sx;
    mem_sel           = sel;
    mem_addr          = addr;
    mem_write_data    = wdata;
    if (!(req && !mis)) begin
      // A stray ready while idle must be ignored.
      ram_ready     = 1'($urandom);
      ram_read_data = $urandom;
    end

    @(negedge clk);
    n_checks++;
    if (stall_request !== (req && !mis)) begin
      n_fail++;
      $display("FAIL %s req_stall: got %0b expected %0b", tag, stall_request, req && !mis);
    end

    if (!(req && !mis)) begin
      @(posedge clk); #1;
      clear_inputs();
      ram_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (addr_error !== (req && mis)) begin
        n_fail++;
        $display("FAIL %s addr_error: got %0b expected %0b", tag, addr_error, req && mis);
      end
      n_checks++;
      if (ram_en !== 1'b0 || stall_request !== 1'b0) begin
        n_fail++;
        $display("FAIL %s no_bus: got ram_en=%0b stall=%0b expected 0 0", tag, ram_en, stall_request);
      end
      n_checks++;
      if (load_data !== exp_load) begin
        n_fail++;
        $display("FAIL %s load_hold: got %h expected %h", tag, load_data, exp_load);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if (addr_error !== 1'b0) begin
        n_fail++;
        $display("FAIL %s addr_error_pulse: got %0b expected 0", tag, addr_error);
      end
      @(posedge clk); #1;
      return;
    end

    @(posedge clk);
    for (int k = 0; k < T; k++) begin
      #1;
      rdy           = (k == delay);
      ram_ready     = rdy;
      ram_read_data = rdy ? rdata : $urandom;
      @(negedge clk);
      n_checks++;
      if (ram_en !== 1'b1 || stall_request !== 1'b1) begin
        n_fail++;
        $display("FAIL %s busy%0d: got ram_en=%0b stall=%0b expected 1 1", tag, k, ram_en, stall_request);
      end
      n_checks++;
      if (ram_write_en !== exp_we || ram_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL %s bus_ctl%0d: got we=%b addr=%h expected we=%b addr=%h",
                 tag, k, ram_write_en, ram_addr, exp_we, exp_addr);
      end
      if (wr) begin
        n_checks++;
        if (ram_write_data !== exp_wdata) begin
          n_fail++;
          $display("FAIL %s wdata%0d: got %h expected %h", tag, k, ram_write_data, exp_wdata);
        end
      end
      @(posedge clk);
      if (rdy) break;
    end

    // DONE cycle: model update then observation.
    #1;
    ram_ready = 1'b0;
    clear_inputs();
    ok = (delay < T);
    if (!ok) begin
      exp_load = 32'd0;
    end else if (is_load) begin
      b = (rdata >> (8 * (addr % 4))) & 32'hFF;
      exp_load = word ? rdata : ((sx && b >= 128) ? b + 32'hFFFF_FF00 : b);
    end
    @(negedge clk);
    n_checks++;
    if (stall_request !== 1'b0 || ram_en !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done: got stall=%0b ram_en=%0b expected 0 0", tag, stall_request, ram_en);
    end
    n_checks++;
    if (bus_error !== !ok) begin
      n_fail++;
      $display("FAIL %s bus_error: got %0b expected %0b", tag, bus_error, !ok);
    end
    n_checks++;
    if (load_data !== exp_load) begin
      n_fail++;
      $display("FAIL %s load_data: got %h expected %h", tag, load_data, exp_load);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    ram_ready     = 1'b0;
    ram_read_data = 32'd0;
    rst_n         = 1'b0;
    #12;
    n_checks++;
    if (ram_en !== 1'b0 || ram_write_en !== 4'h0 || ram_addr !== 32'd0 || ram_write_data !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_bus: got en=%0b we=%b addr=%h wd=%h expected all zero",
               ram_en, ram_write_en, ram_addr, ram_write_data);
    end
    n_checks++;
    if (load_data !== 32'd0 || addr_error !== 1'b0 || bus_error !== 1'b0 || stall_request !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: got ld=%h ae=%0b be=%0b stall=%0b expected all zero",
               load_data, addr_error, bus_error, stall_request);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_store();
    do_access(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1, "word_store");
  endtask

  task automatic test_byte_store();
    do_access(1'b0, 1'b1, 1'b0, 4'h1, 32'h0000_0013, 32'h1234_56A5, 32'd0, 0, "byte_store");
  endtask

  task automatic test_byte_load();
    do_access(1'b1, 1'b0, 1'b1, 4'h1, 32'h0000_0021, 32'd0, 32'h0000_8000, 0, "byte_load_sx");
    do_access(1'b1, 1'b0, 1'b0, 4'h1, 32'h0000_0021, 32'd0, 32'h0000_8000, 0, "byte_load_zx");
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0006, 32'd0, 32'd0, 0, "misaligned");
  endtask

  task automatic test_timeout();
    // Seed load_data with a non-zero value so the clear on timeout is visible.
    do_access(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0040, 32'd0, 32'hCAFE_F00D, 2, "preload");
    do_access(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0044, 32'd0, 32'h1111_2222, 99, "timeout");
    @(negedge clk);
    n_checks++;
    if (bus_error !== 1'b0 || ram_en !== 1'b0 || stall_request !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle: got be=%0b en=%0b stall=%0b expected 0 0 0", bus_error, ram_en, stall_request);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy();
    mem_read_flag = 1'b1;
    mem_sel       = 4'hF;
    mem_addr      = 32'h0000_0080;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (ram_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_busy_pre: got ram_en=%0b expected 1", ram_en);
    end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    exp_load = 32'd0;
    n_checks++;
    if (ram_en !== 1'b0 || stall_request !== 1'b0 || load_data !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_busy: got en=%0b stall=%0b ld=%h expected 0 0 0", ram_en, stall_request, load_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0084, 32'd0, 32'h0BAD_F00D, 1, "post_reset");
  endtask

  task automatic test_back_to_back();
    do_access(1'b1, 1'b1, 1'b0, 4'h1, 32'h0000_0102, 32'h0000_00C3, 32'h5555_5555, 0, "both_flags");
    do_access(1'b1, 1'b0, 1'b1, 4'h1, 32'h0000_0103, 32'd0, 32'h7F00_0000, 0, "b2b_load");
    do_access(1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0100, 32'd0, 32'd0, 0, "no_flags");
    do_access(1'b1, 1'b0, 1'b0, 4'h3, 32'h0000_0100, 32'd0, 32'd0, 0, "bad_sel");
  endtask

  task automatic test_random();
    logic [3:0] sel;
    int         pick;
    for (int i = 0; i < 60; i++) begin
      pick = $urandom_range(0, 4);
      sel  = (pick < 2) ? 4'h1 : (pick < 4) ? 4'hF : 4'($urandom);
      do_access(1'($urandom), 1'($urandom), 1'($urandom), sel, $urandom, $urandom, $urandom,
                $urandom_range(0, T + 1), "random");
    end
  endtask

  initial begin
    rst_n = 1'b1;
    test_reset();
    test_word_store();
    test_byte_store();
    test_byte_load();
    test_misaligned();
    test_timeout();
    test_reset_mid_busy();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
